// File: rtl/dataset_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : dataset_writer_if
// Purpose  : Bundles the sample-input strobes and the dataset RAM write port
//            of dataset_writer into one interface.
// Ports    : slave  - dataset_writer side (samples in, RAM port/status out)
//            master - upstream source / observer side (the mirror image)
// Revision : 1.0 - initial release
// ============================================================================
interface dataset_writer_if #(
  parameter int DATA_W = 7,
  parameter int ADDR_W = 6
);
  logic              startAgain;
  logic              putData;
  logic              lastData;
  logic [DATA_W-1:0] dataIn;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memData;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              wrFinish;
  logic              overflow;

  modport slave (
    input  startAgain, putData, lastData, dataIn,
    output memWe, memAddr, memData, count, full, wrFinish, overflow
  );

  modport master (
    output startAgain, putData, lastData, dataIn,
    input  memWe, memAddr, memData, count, full, wrFinish, overflow
  );
endinterface
`default_nettype wire

// File: rtl/dataset_writer.sv
`default_nettype none
// ============================================================================
// Module   : dataset_writer
// Purpose  : Write side of the regression dataset store. Accepts one sample
//            per putData strobe and drives a registered write port into the
//            dataset RAM; tracks fill level, end of dataset and overflow.
// Ports    : clk  - clock, all logic on rising edge
//            rst  - synchronous active-high reset
//            bus  - dataset_writer_if.slave:
//                     startAgain/putData/lastData/dataIn  (in)
//                     memWe/memAddr/memData               (out, registered)
//                     count/full/wrFinish/overflow        (out, status)
// Revision : 1.0 - initial release
// ============================================================================
module dataset_writer #(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  wire logic         clk,
  input  wire logic         rst,
  dataset_writer_if.slave   bus
);

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state,    w_state_nx;
  logic                r_we,       w_we_nx;
  logic [ADDR_W-1:0]   r_addr,     w_addr_nx;
  logic [DATA_W-1:0]   r_data,     w_data_nx;
  logic [ADDR_W:0]     r_count,    w_count_nx;
  logic [ADDR_W-1:0]   r_wr_ptr,   w_wr_ptr_nx;
  logic                r_overflow, w_overflow_nx;

  // Next-state and next-output logic.
  always_comb begin
    w_state_nx    = r_state;
    w_we_nx       = 1'b0;           // memWe is a single-cycle pulse
    w_addr_nx     = r_addr;         // address/data hold between writes
    w_data_nx     = r_data;
    w_count_nx    = r_count;
    w_wr_ptr_nx   = r_wr_ptr;
    w_overflow_nx = r_overflow;

    if (bus.startAgain) begin
      // Same clearing as reset; a coincident putData is dropped.
      w_state_nx    = S_IDLE;
      w_addr_nx     = '0;
      w_data_nx     = '0;
      w_count_nx    = '0;
      w_wr_ptr_nx   = '0;
      w_overflow_nx = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.putData) begin
            w_we_nx     = 1'b1;
            w_addr_nx   = '0;
            w_data_nx   = bus.dataIn;
            w_wr_ptr_nx = ADDR_W'(1);
            w_count_nx  = (ADDR_W+1)'(1);
            w_state_nx  = bus.lastData ? S_DONE : S_FILL;
          end
        end
        S_FILL: begin
          if (bus.putData) begin
            if (r_count < c_depth) begin
              w_we_nx     = 1'b1;
              w_addr_nx   = r_wr_ptr;
              w_data_nx   = bus.dataIn;
              // Pointer wraps after the last entry; full blocks reuse.
              w_wr_ptr_nx = r_wr_ptr + ADDR_W'(1);
              w_count_nx  = r_count + (ADDR_W+1)'(1);
              if (bus.lastData) begin
                w_state_nx = S_DONE;
              end
            end else begin
              // Refused write: flag it and close the dataset.
              w_overflow_nx = 1'b1;
              w_state_nx    = S_DONE;
            end
          end
        end
        S_DONE: begin
          // Writes ignored until startAgain or rst.
        end
        default: begin
          w_state_nx = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_we       <= w_we_nx;
      r_addr     <= w_addr_nx;
      r_data     <= w_data_nx;
      r_count    <= w_count_nx;
      r_wr_ptr   <= w_wr_ptr_nx;
      r_overflow <= w_overflow_nx;
    end
  end

  assign bus.memWe    = r_we;
  assign bus.memAddr  = r_addr;
  assign bus.memData  = r_data;
  assign bus.count    = r_count;
  assign bus.full     = (r_count == c_depth);
  assign bus.wrFinish = (r_state == S_DONE);
  assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_dataset_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dataset_writer
// Purpose  : Self-checking bench for dataset_writer. Directed scenarios
//            followed by randomized traffic, compared every cycle against a
//            behavioural model of the dataset buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dataset_writer;

  localparam int DATA_W = 7;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dataset_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dataset_writer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Behavioural model: the buffer is just a fill count plus two flags.
  int m_count, m_addr, m_data;
  bit m_done, m_ovf, m_we;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cycle, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare all outputs.
  task automatic step(input bit r, input bit sa, input bit pd, input bit ld,
                      input logic [DATA_W-1:0] din);
    rst            = r;
    bus.startAgain = sa;
    bus.putData    = pd;
    bus.lastData   = ld;
    bus.dataIn     = din;
    @(posedge clk);
    #1;
    cycle++;
    m_we = 1'b0;
    if (r || sa) begin
      m_count = 0; m_done = 1'b0; m_ovf = 1'b0; m_addr = 0; m_data = 0;
    end else if (pd && !m_done) begin
      if (m_count < DEPTH) begin
        m_we    = 1'b1;
        m_addr  = m_count;
        m_data  = int'(din);
        m_count = m_count + 1;
        if (ld) m_done = 1'b1;
      end else begin
        m_ovf  = 1'b1;
        m_done = 1'b1;
      end
    end
    check("memWe",    int'(bus.memWe),    int'(m_we));
    check("memAddr",  int'(bus.memAddr),  m_addr);
    check("memData",  int'(bus.memData),  m_data);
    check("count",    int'(bus.count),    m_count);
    check("full",     int'(bus.full),     int'(m_count == DEPTH));
    check("wrFinish", int'(bus.wrFinish), int'(m_done));
    check("overflow", int'(bus.overflow), int'(m_ovf));
  endtask

  initial begin
    m_count = 0; m_addr = 0; m_data = 0;
    m_done = 1'b0; m_ovf = 1'b0; m_we = 1'b0;

    // Reset, then five writes with lastData on the fifth.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) step(0, 0, 1, (i == 5), 7'(i));
    step(0, 0, 1, 0, 7'h33);                 // ignored in DONE

    // Fill all entries, then one refused write.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 1, 0, 7'($urandom));
    step(0, 0, 0, 0, 0);

    // Reset while done with overflow, coincident with putData.
    step(1, 0, 1, 0, 7'h11);
    step(0, 0, 0, 0, 0);

    // Single sample with lastData from IDLE.
    step(0, 0, 1, 1, 7'h7F);
    step(0, 0, 1, 0, 7'h22);
    step(0, 0, 1, 1, 7'h23);

    // Three writes, then startAgain with a fourth strobe, then a new write.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 7'(10 + i));
    step(0, 1, 1, 0, 7'h44);
    step(0, 0, 1, 0, 7'h45);

    // lastData without putData during FILL has no effect.
    step(0, 0, 0, 1, 7'h50);
    step(0, 0, 1, 0, 7'h51);

    // Randomized traffic; some episodes never raise lastData so the
    // buffer fills and overflows.
    for (int e = 0; e < 50; e++) begin
      int plast;
      int len;
      plast = $urandom_range(0, 3);
      len   = $urandom_range(10, 130);
      for (int i = 0; i < len; i++) begin
        step(($urandom_range(0, 149) == 0),
             ($urandom_range(0, 79) == 0),
             ($urandom_range(0, 4) != 0),
             (plast != 0) && ($urandom_range(0, 29) < plast),
             7'($urandom));
      end
      if ($urandom_range(0, 1) == 1) step(0, 1, ($urandom_range(0, 1) == 1), 0, 7'($urandom));
      else                           step(1, 0, ($urandom_range(0, 1) == 1), 0, 7'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
